mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single shared RAM port between the instruction cache and the data cache. It accepts word requests from both caches, grants one at a time, and holds the grant until the RAM reports completion. It returns the per-cache wait/load signals the caches use to build `ihit`/`dhit`. It sits between the `icache`/`dcache` pair and the RAM model / bus interface.

## Interface
Parameters:
- `DATA_STREAK_MAX`, default 4: consecutive data grants allowed while an instruction request is pending. Used only when fairness is compiled in.
- `ERR_WORD`, default 32'hBAD1BAD1: load value returned on a RAM error.

Ports:
- `CLK` in 1: clock. All state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `iREN` in 1: instruction read request.
- `iaddr` in 32: instruction word address.
- `iwait` out 1: instruction access not complete.
- `iload` out 32: instruction read data.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data word address.
- `dstore` in 32: data write value.
- `dwait` out 1: data access not complete.
- `dload` out 32: data read data.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in `ramstate_t`: RAM status, one of FREE, BUSY, ACCESS, ERROR.
- `arb_err` out 1: sticky RAM-error flag. Cleared only by `RST`.

## Operation
- State machine `arb_state_t`:
  - `ARB_IDLE`: no grant.
  - `ARB_IGNT`: instruction cache owns the port.
  - `ARB_DGNT`: data cache owns the port.
- Transitions out of IDLE, evaluated each edge:
  - `dREN|dWEN` → DGNT.
  - else `iREN` → IGNT.
  - else stay IDLE.
- Data requests have priority (fairness exception in Configuration).
- In IGNT:
  - `ramREN`=1, `ramaddr`=`iaddr`, `ramWEN`=0, `ramstore`=0.
- In DGNT:
  - `ramaddr`=`daddr`.
  - `dWEN`=1 → `ramWEN`=1, `ramREN`=0, `ramstore`=`dstore`. Write wins when `dREN` and `dWEN` are both high.
  - else `ramREN`=1.
- In IDLE: all RAM outputs are 0.
- Completion, when the granted requester sees `ramstate`==ACCESS:
  - Its wait goes to 0 combinationally in the same cycle.
  - Its load = `ramload`.
  - State returns to IDLE on the next edge.
- Error, when `ramstate`==ERROR during a grant:
  - Treated as completion; load = `ERR_WORD`.
  - `arb_err` is set on the next edge.
- Wait and load defaults:
  - A wait is 1 whenever its cache requests and is not completing this cycle. It is 0 when that cache is not requesting.
  - The non-granted load output is 0.
- Abort: if the granted requester drops its request before completion, the state returns to IDLE on the next edge. RAM enables drop combinationally in the same cycle.
- FREE or BUSY during a grant: hold the grant; waits stay high.

## Timing
- Reset values: state IDLE, `arb_err`=0, `ramREN`/`ramWEN`=0, `ramaddr`/`ramstore`=0, `iload`/`dload`=0. Waits follow the rule above, so they are 1 for any active request.
- Arbitration latency: request seen in cycle N, grant in N+1.
- Earliest wait deassertion is cycle N+1, if the RAM gives ACCESS immediately.
- One mandatory IDLE bubble follows every completion. Back-to-back accesses from the same cache take a minimum of 2 cycles each.
- Requests must hold address and data stable until wait=0. The arbiter does not latch them.
- `RST` asserted mid-grant: IDLE next edge; the access is abandoned and the RAM enables go low that edge.
- Simultaneous first requests from both caches: data wins. The instruction request waits at least until the data completion plus the bubble.

## Configuration
- Macro `MEM_ARB_FAIRNESS_EN`:
  - Defined: a saturating streak counter counts DGNT entries made while `iREN` is high. It resets to 0 on any IGNT entry, or when an IDLE arbitration sees `iREN`=0.
  - When the count equals `DATA_STREAK_MAX`, the next IDLE arbitration with `iREN` high goes to IGNT even if data is requesting.
  - Undefined: strict data priority, no counter hardware. An instruction request can starve.

## Structure
- `cpu_types_pkg` holds:
  - `ramstate_t` (existing).
  - new `arb_state_t`.
  - `ERR_WORD` default as a localparam constant.
- Sub-module `mem_arb_streak`: the fairness counter. Instantiated only under `MEM_ARB_FAIRNESS_EN`. Inputs: `dgnt_enter`, `ignt_enter`, `ipend`. Output: `force_i`.

## Test plan
- Reset with `iREN`=1, `iaddr`=0x40 → `ramREN`=0, `iwait`=1. Release `RST`, RAM ACCESS next cycle → `ramaddr`=0x40 that cycle, `iwait`=0, `iload`=`ramload`.
- `iREN` and `dREN` asserted in the same cycle, RAM ACCESS after 2 BUSY cycles → data served first (cycles 1-3), IDLE bubble, instruction granted at cycle 5.
- `dWEN`=1 and `dREN`=1, `daddr`=0x100, `dstore`=0xCAFEF00D → `ramWEN`=1, `ramREN`=0, `ramstore`=0xCAFEF00D.
- `ramstate`=ERROR during IGNT → `iwait`=0, `iload`=0xBAD1BAD1, `arb_err`=1 from the next cycle until `RST`.
- Data request dropped mid-grant (BUSY) → RAM enables 0 the same cycle, IDLE the next cycle, a pending `iREN` is granted the cycle after.
- With `MEM_ARB_FAIRNESS_EN`, `DATA_STREAK_MAX`=4, continuous `dREN` and `iREN` → exactly 4 data grants, then 1 instruction grant, pattern repeats. Without the macro, `iwait` never falls.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM status, arbiter states and the arbiter error word.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IGNT = 2'd1,
      ARB_DGNT = 2'd2
   } arb_state_t;

   localparam logic [31:0] ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_arb_streak.sv
// Data-grant streak counter; asks for an instruction grant once data has won
// STREAK_MAX arbitrations in a row while an instruction request was waiting.
module mem_arb_streak #(
   parameter int unsigned STREAK_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_idle,
   input  logic dgnt_enter,
   input  logic ignt_enter,
   input  logic ipend,
   output logic force_i
);

   localparam int unsigned CW = $clog2(STREAK_MAX + 1);

   logic [CW-1:0] r_count;

   // dgnt_enter only happens from IDLE, so a data entry with no pending
   // instruction request is itself an "IDLE arbitration with iREN low".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (ignt_enter || (arb_idle && !ipend)) begin
         r_count <= '0;
      end else if (dgnt_enter && (r_count != CW'(STREAK_MAX))) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign force_i = (r_count == CW'(STREAK_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between icache and dcache. Optional instruction
// fairness is compiled in with MEM_ARB_FAIRNESS_EN.
//
// state    | meaning
// ARB_IDLE | no grant; arbitrate on this edge (data first unless forced)
// ARB_IGNT | instruction cache owns the RAM port
// ARB_DGNT | data cache owns the RAM port
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned DATA_STREAK_MAX = 4,
   parameter logic [31:0] ERR_WORD        = ERR_WORD_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate,
   output logic        arb_err
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   logic        r_arb_err;
   logic        w_dreq;
   logic        w_ram_done;
   logic [31:0] w_load_val;
   logic        w_icomp;
   logic        w_dcomp;
   logic        w_force_i;
   logic        w_arb_idle;
   logic        w_dgnt_enter;
   logic        w_ignt_enter;

   assign w_dreq     = dREN | dWEN;
   assign w_ram_done = (ramstate == ACCESS) || (ramstate == ERROR);
   assign w_load_val = (ramstate == ERROR) ? ERR_WORD : ramload;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ARB_IDLE;
         r_arb_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((w_icomp || w_dcomp) && (ramstate == ERROR)) begin
            r_arb_err <= 1'b1;
         end
      end
   end

   // A granted requester that drops its request loses the port immediately.
   always_comb begin
      w_state_nxt = r_state;
      w_icomp     = 1'b0;
      w_dcomp     = 1'b0;
      iload       = '0;
      dload       = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      case (r_state)
         ARB_IDLE: begin
            if (w_force_i && iREN) begin
               w_state_nxt = ARB_IGNT;
            end else if (w_dreq) begin
               w_state_nxt = ARB_DGNT;
            end else if (iREN) begin
               w_state_nxt = ARB_IGNT;
            end
         end
         ARB_IGNT: begin
            if (!iREN) begin
               w_state_nxt = ARB_IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (w_ram_done) begin
                  w_icomp     = 1'b1;
                  iload       = w_load_val;
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         ARB_DGNT: begin
            if (!w_dreq) begin
               w_state_nxt = ARB_IDLE;
            end else begin
               ramaddr = daddr;
               if (dWEN) begin
                  ramWEN   = 1'b1;
                  ramstore = dstore;
               end else begin
                  ramREN = 1'b1;
               end
               if (w_ram_done) begin
                  w_dcomp     = 1'b1;
                  dload       = w_load_val;
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   assign iwait   = iREN & ~w_icomp;
   assign dwait   = w_dreq & ~w_dcomp;
   assign arb_err = r_arb_err;

   assign w_arb_idle   = (r_state == ARB_IDLE);
   assign w_dgnt_enter = w_arb_idle && (w_state_nxt == ARB_DGNT);
   assign w_ignt_enter = w_arb_idle && (w_state_nxt == ARB_IGNT);

`ifdef MEM_ARB_FAIRNESS_EN
   mem_arb_streak #(
      .STREAK_MAX (DATA_STREAK_MAX)
   ) u_streak (
      .clk        (CLK),
      .rst        (RST),
      .arb_idle   (w_arb_idle),
      .dgnt_enter (w_dgnt_enter),
      .ignt_enter (w_ignt_enter),
      .ipend      (iREN),
      .force_i    (w_force_i)
   );
`else
   logic w_unused_streak;
   assign w_unused_streak = ^{DATA_STREAK_MAX, w_dgnt_enter, w_ignt_enter};
   assign w_force_i       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, priority, write, error, abort and
// data-streak behaviour (with or without MEM_ARB_FAIRNESS_EN).
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic        iwait, dwait, ramREN, ramWEN, arb_err;
   logic [31:0] iload, dload, ramaddr, ramstore;
   ramstate_t   ramstate;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   mem_arbiter #(
      .DATA_STREAK_MAX (4),
      .ERR_WORD        (32'hBAD1BAD1)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .arb_err  (arb_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [19:0] seq;
      logic [19:0] seq_exp;
      int          ngnt;
      logic        ifell;

      RST = 1'b1; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
      daddr = '0; dstore = '0; ramload = 32'h12345678; ramstate = FREE;

      // reset with an instruction request present
      cyc(); cyc(); #1;
      check("rst_ramREN", ramREN, 0);
      check("rst_iwait", iwait, 1);
      check("rst_arb_err", arb_err, 0);
      check("rst_iload", iload, 0);
      check("rst_ramaddr", ramaddr, 0);
      RST = 1'b0; #1;
      check("idle_iwait", iwait, 1);
      cyc(); ramstate = ACCESS; #1;
      check("i_ramaddr", ramaddr, 32'h40);
      check("i_ramREN", ramREN, 1);
      check("i_iwait", iwait, 0);
      check("i_iload", iload, 32'h12345678);
      cyc(); iREN = 1'b0; ramstate = FREE; #1;
      check("i_bubble_ramREN", ramREN, 0);

      // simultaneous requests: data first, then bubble, then instruction
      iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h200;
      ramstate = BUSY; ramload = 32'hA5A5A5A5;
      cyc(); #1;
      check("pri_c1_ramaddr", ramaddr, 32'h200);
      check("pri_c1_ramREN", ramREN, 1);
      check("pri_c1_dwait", dwait, 1);
      check("pri_c1_iwait", iwait, 1);
      cyc(); #1;
      check("pri_c2_dwait", dwait, 1);
      cyc(); ramstate = ACCESS; #1;
      check("pri_c3_dwait", dwait, 0);
      check("pri_c3_dload", dload, 32'hA5A5A5A5);
      check("pri_c3_iwait", iwait, 1);
      check("pri_c3_iload", iload, 0);
      cyc(); dREN = 1'b0; ramstate = FREE; #1;
      check("pri_c4_ramREN", ramREN, 0);
      check("pri_c4_iwait", iwait, 1);
      cyc(); ramstate = ACCESS; ramload = 32'h5A5A0001; #1;
      check("pri_c5_ramaddr", ramaddr, 32'h44);
      check("pri_c5_ramREN", ramREN, 1);
      check("pri_c5_iwait", iwait, 0);
      check("pri_c5_iload", iload, 32'h5A5A0001);
      cyc(); iREN = 1'b0; ramstate = FREE;

      // write wins over read
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hCAFEF00D; #1;
      check("wr_idle_ramWEN", ramWEN, 0);
      cyc(); #1;
      check("wr_ramWEN", ramWEN, 1);
      check("wr_ramREN", ramREN, 0);
      check("wr_ramstore", ramstore, 32'hCAFEF00D);
      check("wr_ramaddr", ramaddr, 32'h100);
      check("wr_dwait_busy", dwait, 1);
      cyc(); ramstate = ACCESS; #1;
      check("wr_dwait_done", dwait, 0);
      cyc(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
      check("wr_bubble_ramWEN", ramWEN, 0);

      // RAM error during instruction grant
      iREN = 1'b1; iaddr = 32'h80;
      cyc(); ramstate = ERROR; #1;
      check("err_iwait", iwait, 0);
      check("err_iload", iload, 32'hBAD1BAD1);
      check("err_flag_same", arb_err, 0);
      cyc(); iREN = 1'b0; ramstate = FREE; #1;
      check("err_flag_next", arb_err, 1);
      cyc(); cyc(); #1;
      check("err_flag_sticky", arb_err, 1);

      // data request dropped mid-grant
      dREN = 1'b1; iREN = 1'b1; daddr = 32'h240; iaddr = 32'h88; ramstate = BUSY;
      cyc(); #1;
      check("abt_ramREN", ramREN, 1);
      check("abt_ramaddr", ramaddr, 32'h240);
      dREN = 1'b0; #1;
      check("abt_same_ramREN", ramREN, 0);
      cyc(); #1;
      check("abt_idle_ramREN", ramREN, 0);
      check("abt_idle_iwait", iwait, 1);
      cyc(); #1;
      check("abt_i_ramREN", ramREN, 1);
      check("abt_i_ramaddr", ramaddr, 32'h88);
      ramstate = ACCESS; #1;
      check("abt_i_iwait", iwait, 0);
      cyc(); iREN = 1'b0; ramstate = FREE;

      // reset clears the sticky error
      RST = 1'b1;
      cyc(); #1;
      check("err_cleared", arb_err, 0);

      // continuous data and instruction traffic
      RST = 1'b0; dREN = 1'b1; iREN = 1'b1; daddr = 32'h300; iaddr = 32'h500;
      ramstate = ACCESS;
      seq = '0; ngnt = 0; ifell = 1'b0;
      for (int k = 0; k < 40; k++) begin
         cyc(); #1;
         if (!iwait) ifell = 1'b1;
         if (ramREN && ngnt < 20) begin
            if (ramaddr == 32'h500) seq[ngnt] = 1'b1;
            ngnt++;
         end
      end
`ifdef MEM_ARB_FAIRNESS_EN
      seq_exp = 20'h84210;
      check("fair_ifell", 32'(ifell), 1);
`else
      seq_exp = 20'h00000;
      check("starve_ifell", 32'(ifell), 0);
`endif
      check("streak_ngnt", ngnt, 20);
      check("streak_seq", 32'(seq), 32'(seq_exp));
      dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
